// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 raster constants, colours and range helper
package vga_timing_pkg;
  localparam int CW       = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [5:0] FG_RGB = 6'b111111;
  localparam logic [5:0] BG_RGB = 6'b000000;
  function automatic logic in_range(input logic [CW-1:0] x, input int lo, input int hi);
    return x >= CW'(lo) && x <= CW'(hi);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis - count with wrap, terminal count, sync and active decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc,
  output logic          sync,
  output logic          active
);
  if (TOTAL > 1024 || ACTIVE > TOTAL || SYNC_LEN < 1 || SYNC_START + SYNC_LEN > TOTAL) begin : g_bad_timing
    $error("vga_axis_counter: illegal timing parameters");
  end
  assign tc     = count == CW'(TOTAL - 1);
  assign sync   = in_range(count, SYNC_START, SYNC_START + SYNC_LEN - 1);
  assign active = count < CW'(ACTIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster timing master, sync/blank delayed to match renderer pixel latency
module vga_scan_driver #(
  parameter int         H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int         H_FP     = vga_timing_pkg::H_FP,
  parameter int         H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int         H_BP     = vga_timing_pkg::H_BP,
  parameter int         V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int         V_FP     = vga_timing_pkg::V_FP,
  parameter int         V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int         V_BP     = vga_timing_pkg::V_BP,
  parameter bit         SYNC_POL = 1'b0,
  parameter int         PIX_LAT  = 1,
  parameter logic [5:0] FG_RGB   = vga_timing_pkg::FG_RGB,
  parameter logic [5:0] BG_RGB   = vga_timing_pkg::BG_RGB
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_ce,
  input  logic       pixel_bw,
  output logic [9:0] horizCounter,
  output logic [9:0] vertCounter,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       vblank,
  output logic       frame_start,
  output logic [5:0] rgb
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_scan_driver: PIX_LAT must be 1..4");
  end
  logic       h_tc, v_tc, hs, vs, h_act, v_act;
  logic [2:0] dly [PIX_LAT];
  logic       hs_d, vs_d, de_d, ce_q, px_q, px;
  vga_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .SYNC_START(H_ACTIVE + H_FP), .SYNC_LEN(H_SYNC)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .en(pix_ce),
    .count(horizCounter), .tc(h_tc), .sync(hs), .active(h_act)
  );
  vga_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .SYNC_START(V_ACTIVE + V_FP), .SYNC_LEN(V_SYNC)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .en(pix_ce & h_tc),
    .count(vertCounter), .tc(v_tc), .sync(vs), .active(v_act)
  );
  assign {hs_d, vs_d, de_d} = dly[PIX_LAT-1];
  assign vblank = ~v_act;
  // renderer output is fresh one clk after a shift; with slower pix_ce it has moved on, so use the held copy
  assign px = ce_q ? pixel_bw : px_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < PIX_LAT; i++) dly[i] <= '0;
    end else if (pix_ce) begin
      dly[0] <= {hs, vs, h_act & v_act};
      for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ce_q <= 1'b0;
      px_q <= 1'b0;
    end else begin
      ce_q <= pix_ce;
      if (ce_q) px_q <= pixel_bw;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      display_on  <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hsync       <= SYNC_POL ? hs_d : ~hs_d;
      vsync       <= SYNC_POL ? vs_d : ~vs_d;
      display_on  <= de_d;
      rgb         <= de_d ? (px ? FG_RGB : BG_RGB) : '0;
      frame_start <= h_tc & v_tc;
    end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: scoreboard bench, raster model indexed by pix_ce count since reset
module tb_vga_scan_driver;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [5:0] FG = 6'b111111, BG = 6'b001001;

  typedef struct packed {
    logic [9:0] h, v;
    logic       hsync, vsync, de, fs, vb;
    logic [5:0] rgb;
  } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0, pixel_bw = 1'b0;
  logic [9:0] horizCounter, vertCounter;
  logic       hsync, vsync, display_on, vblank, frame_start;
  logic [5:0] rgb;
  int         n_chk = 0, n_fail = 0, k = 0, mode = 0, key = 0;
  exp_t       q[$];

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .PIX_LAT(1), .FG_RGB(FG), .BG_RGB(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .pixel_bw(pixel_bw),
    .horizCounter(horizCounter), .vertCounter(vertCounter),
    .hsync(hsync), .vsync(vsync), .display_on(display_on), .vblank(vblank),
    .frame_start(frame_start), .rgb(rgb)
  );

  always #5 clk = ~clk;

  function automatic logic pix(input int h, input int v);
    if (mode == 1) return 1'b1;
    if (mode == 2) return 1'(((h * 7 + v * 13 + key) >> 2) & 1);
    return 1'((h ^ v) & 1);
  endfunction

  // renderer: registers its pixel from the counters on every clk
  always @(posedge clk) pixel_bw <= pix(int'(horizCounter), int'(vertCounter));

  // expected outputs after the k-th pix_ce edge since reset; outputs show counter index k-2
  function automatic exp_t model(input int kk);
    exp_t e;
    int   t, p, ph, pv;
    t = kk % FRAME;
    e.h = 10'(t % HT);
    e.v = 10'(t / HT);
    e.fs = kk > 0 && t == 0;
    e.vb = (t / HT) >= VA;
    e.hsync = 1'b1;
    e.vsync = 1'b1;
    e.de = 1'b0;
    e.rgb = '0;
    if (kk >= 2) begin
      p = (kk - 2) % FRAME;
      ph = p % HT;
      pv = p / HT;
      e.hsync = !(ph >= HA + HF && ph < HA + HF + HS);
      e.vsync = !(pv >= VA + VF && pv < VA + VF + VS);
      e.de = ph < HA && pv < VA;
      e.rgb = e.de ? (pix(ph, pv) ? FG : BG) : 6'b0;
    end
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic check(input exp_t e);
    cmp("horizCounter", 16'(horizCounter), 16'(e.h));
    cmp("vertCounter", 16'(vertCounter), 16'(e.v));
    cmp("hsync", 16'(hsync), 16'(e.hsync));
    cmp("vsync", 16'(vsync), 16'(e.vsync));
    cmp("display_on", 16'(display_on), 16'(e.de));
    cmp("frame_start", 16'(frame_start), 16'(e.fs));
    cmp("vblank", 16'(vblank), 16'(e.vb));
    cmp("rgb", 16'(rgb), 16'(e.rgb));
  endtask

  localparam exp_t RST = '{h: 10'd0, v: 10'd0, hsync: 1'b1, vsync: 1'b1, de: 1'b0, fs: 1'b0, vb: 1'b0, rgb: 6'd0};

  initial begin : monitor
    logic ce_s, rs_s;
    forever begin
      @(posedge clk);
      ce_s = pix_ce;
      rs_s = rst_n;
      #1;
      if (!rs_s) check(RST);
      else if (ce_s) begin
        if (q.size() == 0) cmp("scoreboard_underflow", 16'(q.size()), 16'd1);
        else check(q.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    #1 check(RST);
  end

  task automatic do_reset(input int new_mode);
    rst_n = 1'b0;
    pix_ce = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
    k = 0;
    mode = new_mode;
    key = int'($urandom_range(0, 255));
    rst_n = 1'b1;
  endtask

  // duty: 0 = every clk, 1 = one in two, 2 = random
  task automatic run(input int cnt, input int duty);
    int n = 0;
    int ph = 0;
    while (n < cnt) begin
      pix_ce = duty == 0 ? 1'b1 : duty == 1 ? 1'(ph) : 1'($urandom_range(0, 2) != 0);
      ph ^= 1;
      if (pix_ce) begin
        k++;
        n++;
        q.push_back(model(k));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(0);
    run(3 * FRAME + 5, 0);
    do_reset(0);
    run(2 * FRAME + 3, 1);
    do_reset(1);
    run(FRAME + 10, 0);
    do_reset(2);
    run(2 * FRAME + 7, 2);
    do_reset(0);
    run(7 * HT + 13, 0);
    do_reset(0);
    run(FRAME + 40, 2);
    pix_ce = 1'b0;
    repeat (2) @(negedge clk);
    cmp("scoreboard_drained", 16'(q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
